// File: rtl/branch_resolve_unit_if.sv
// Signal bundle between the core pipeline and the EX-stage branch resolve unit.
// The unit attaches to the slave modport; the pipeline side uses master.
interface branch_resolve_unit_if #(
    parameter int XLEN = 32
);
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic            if_pred_taken;
    logic [XLEN-1:0] if_pred_target;
    logic            stall;
    logic            id_is_branch;
    logic            id_is_jal;
    logic            id_is_jalr;
    logic [2:0]      id_funct3;
    logic [XLEN-1:0] id_imm;
    logic [XLEN-1:0] ex_rs1;
    logic [XLEN-1:0] ex_rs2;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic            upd_prev_taken;
    logic [XLEN-1:0] upd_target;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] ex_link;
    logic [31:0]     perf_branch_cnt;
    logic [31:0]     perf_mispred_cnt;

    modport master (
        output if_valid, if_pc, if_pred_taken, if_pred_target, stall,
               id_is_branch, id_is_jal, id_is_jalr, id_funct3, id_imm,
               ex_rs1, ex_rs2,
        input  upd_valid, upd_pc, upd_taken, upd_prev_taken, upd_target,
               redirect, redirect_pc, ex_link, perf_branch_cnt, perf_mispred_cnt
    );

    modport slave (
        input  if_valid, if_pc, if_pred_taken, if_pred_target, stall,
               id_is_branch, id_is_jal, id_is_jalr, id_funct3, id_imm,
               ex_rs1, ex_rs2,
        output upd_valid, upd_pc, upd_taken, upd_prev_taken, upd_target,
               redirect, redirect_pc, ex_link, perf_branch_cnt, perf_mispred_cnt
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: carries IF prediction metadata to EX, resolves, drives BTB update and redirect.
// Optional performance counters are enabled with the macro BRU_PERF_CNT_EN.
module branch_resolve_unit #(
    parameter int XLEN = 32
) (
    input logic                  clk,
    input logic                  rst,
    branch_resolve_unit_if.slave bus
);
    logic            vld_p0;
    logic [XLEN-1:0] pc_p0;
    logic            pt_p0;
    logic [XLEN-1:0] ptgt_p0;

    logic            vld_p1;
    logic [XLEN-1:0] pc_p1;
    logic            pt_p1;
    logic [XLEN-1:0] ptgt_p1;
    logic            is_br_p1;
    logic            is_jal_p1;
    logic            is_jalr_p1;
    logic [2:0]      funct3_p1;
    logic [XLEN-1:0] imm_p1;

    logic            upd_v;
    logic            taken;
    logic            mispred;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] link;

    function automatic logic branch_cond(input logic [2:0] f3,
                                         input logic [XLEN-1:0] a,
                                         input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        logic                   res;
        sa = a;
        sb = b;
        case (f3)
            3'b000:  res = (a == b);
            3'b001:  res = (a != b);
            3'b100:  res = (sa < sb);
            3'b101:  res = (sa >= sb);
            3'b110:  res = (a < b);
            3'b111:  res = (a >= b);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // IF/ID boundary: redirect squashes even while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            pc_p0   <= '0;
            pt_p0   <= 1'b0;
            ptgt_p0 <= '0;
        end else if (mispred) begin
            vld_p0  <= 1'b0;
        end else if (!bus.stall) begin
            vld_p0  <= bus.if_valid;
            pc_p0   <= bus.if_pc;
            pt_p0   <= bus.if_pred_taken;
            ptgt_p0 <= bus.if_pred_target;
        end
    end

    // ID/EX boundary: stall or redirect injects a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            pc_p1      <= '0;
            pt_p1      <= 1'b0;
            ptgt_p1    <= '0;
            is_br_p1   <= 1'b0;
            is_jal_p1  <= 1'b0;
            is_jalr_p1 <= 1'b0;
            funct3_p1  <= '0;
            imm_p1     <= '0;
        end else if (bus.stall || mispred) begin
            vld_p1     <= 1'b0;
        end else begin
            vld_p1     <= vld_p0;
            pc_p1      <= pc_p0;
            pt_p1      <= pt_p0;
            ptgt_p1    <= ptgt_p0;
            is_br_p1   <= bus.id_is_branch;
            is_jal_p1  <= bus.id_is_jal;
            is_jalr_p1 <= bus.id_is_jalr;
            funct3_p1  <= bus.id_funct3;
            imm_p1     <= bus.id_imm;
        end
    end

    // EX resolution, combinational from ID/EX and forwarded operands
    always_comb begin
        upd_v    = vld_p1 & (is_br_p1 | is_jal_p1 | is_jalr_p1);
        taken    = is_jal_p1 | is_jalr_p1 |
                   (is_br_p1 & branch_cond(funct3_p1, bus.ex_rs1, bus.ex_rs2));
        jalr_sum = bus.ex_rs1 + imm_p1;
        target   = is_jalr_p1 ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_p1 + imm_p1);
        link     = pc_p1 + XLEN'(4);
        mispred  = upd_v & ((taken != pt_p1) | (taken & pt_p1 & (target != ptgt_p1)));
    end

    assign bus.upd_valid      = upd_v;
    assign bus.upd_pc         = pc_p1;
    assign bus.upd_taken      = upd_v & taken;
    assign bus.upd_prev_taken = upd_v & pt_p1;
    assign bus.upd_target     = target;
    assign bus.redirect       = mispred;
    assign bus.redirect_pc    = mispred ? (taken ? target : link) : '0;
    assign bus.ex_link        = link;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (upd_v)   branch_cnt  <= branch_cnt + 32'd1;
            if (mispred) mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

    assign bus.perf_branch_cnt  = branch_cnt;
    assign bus.perf_mispred_cnt = mispred_cnt;
`else
    assign bus.perf_branch_cnt  = '0;
    assign bus.perf_mispred_cnt = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed-vector bench for branch_resolve_unit; expected counter values follow BRU_PERF_CNT_EN.
module tb_branch_resolve_unit;
    logic clk;
    logic rst;
    int   passed;
    int   total;

`ifdef BRU_PERF_CNT_EN
    localparam logic [31:0] EXP_BR3 = 32'd3;
    localparam logic [31:0] EXP_MP1 = 32'd1;
`else
    localparam logic [31:0] EXP_BR3 = 32'd0;
    localparam logic [31:0] EXP_MP1 = 32'd0;
`endif

    branch_resolve_unit_if #(.XLEN(32)) bus ();

    branch_resolve_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    task automatic drive_if(input logic v, input logic [31:0] pc, input logic pt, input logic [31:0] ptgt);
        bus.if_valid       = v;
        bus.if_pc          = pc;
        bus.if_pred_taken  = pt;
        bus.if_pred_target = ptgt;
    endtask

    task automatic drive_id(input logic br, input logic jal, input logic jalr,
                            input logic [2:0] f3, input logic [31:0] imm);
        bus.id_is_branch = br;
        bus.id_is_jal    = jal;
        bus.id_is_jalr   = jalr;
        bus.id_funct3    = f3;
        bus.id_imm       = imm;
    endtask

    // Walks one instruction through IF, ID and into EX; returns with it resolving in EX.
    task automatic issue(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                         input logic br, input logic jal, input logic jalr,
                         input logic [2:0] f3, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        drive_if(1'b1, pc, pt, ptgt);
        drive_id(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
        step();
        drive_if(1'b0, 32'd0, 1'b0, 32'd0);
        drive_id(br, jal, jalr, f3, imm);
        step();
        drive_id(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
        bus.ex_rs1 = rs1;
        bus.ex_rs2 = rs2;
        #1;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        bus.stall  = 1'b0;
        bus.ex_rs1 = 32'd0;
        bus.ex_rs2 = 32'd0;
        drive_if(1'b0, 32'd0, 1'b0, 32'd0);
        drive_id(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_upd_valid", bus.upd_valid, 32'd0);
        chk("rst_redirect", bus.redirect, 32'd0);
        chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
        chk("rst_ex_link", bus.ex_link, 32'd4);
        chk("rst_perf_br", bus.perf_branch_cnt, 32'd0);
        chk("rst_perf_mp", bus.perf_mispred_cnt, 32'd0);
        step();

        // BEQ correctly predicted taken
        issue(32'h100, 1'b1, 32'h120, 1'b1, 1'b0, 1'b0, 3'b000, 32'h20, 32'd5, 32'd5);
        chk("beq_upd_valid", bus.upd_valid, 32'd1);
        chk("beq_upd_pc", bus.upd_pc, 32'h100);
        chk("beq_upd_taken", bus.upd_taken, 32'd1);
        chk("beq_upd_prev", bus.upd_prev_taken, 32'd1);
        chk("beq_upd_target", bus.upd_target, 32'h120);
        chk("beq_redirect", bus.redirect, 32'd0);
        step();
        chk("beq_one_cycle", bus.upd_valid, 32'd0);

        // BLT signed: -1 < 1, predicted not taken
        issue(32'h200, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 3'b100, 32'h40, 32'hFFFF_FFFF, 32'd1);
        chk("blt_upd_taken", bus.upd_taken, 32'd1);
        chk("blt_upd_prev", bus.upd_prev_taken, 32'd0);
        chk("blt_redirect", bus.redirect, 32'd1);
        chk("blt_redirect_pc", bus.redirect_pc, 32'h240);
        step();
        chk("blt_next_ex_bubble", bus.upd_valid, 32'd0);

        // BNE not taken, correctly predicted
        issue(32'h500, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 3'b001, 32'h10, 32'd9, 32'd9);
        chk("bne_upd_valid", bus.upd_valid, 32'd1);
        chk("bne_upd_taken", bus.upd_taken, 32'd0);
        chk("bne_upd_target", bus.upd_target, 32'h510);
        chk("bne_redirect", bus.redirect, 32'd0);
        step();
        chk("perf_br_3", bus.perf_branch_cnt, EXP_BR3);
        chk("perf_mp_1", bus.perf_mispred_cnt, EXP_MP1);

        // JALR wrong target, bit 0 of target cleared
        issue(32'h300, 1'b1, 32'h2000, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0, 32'h1003, 32'd0);
        chk("jalr_redirect", bus.redirect, 32'd1);
        chk("jalr_redirect_pc", bus.redirect_pc, 32'h1002);
        chk("jalr_ex_link", bus.ex_link, 32'h304);
        chk("jalr_upd_target", bus.upd_target, 32'h1002);
        step();

        // BGEU 1 >= 2 false, predicted taken
        issue(32'h400, 1'b1, 32'h480, 1'b1, 1'b0, 1'b0, 3'b111, 32'h80, 32'd1, 32'd2);
        chk("bgeu_upd_taken", bus.upd_taken, 32'd0);
        chk("bgeu_upd_prev", bus.upd_prev_taken, 32'd1);
        chk("bgeu_upd_target", bus.upd_target, 32'h480);
        chk("bgeu_redirect", bus.redirect, 32'd1);
        chk("bgeu_redirect_pc", bus.redirect_pc, 32'h404);
        step();

        // BGE signed: 0x80000000 is negative, so not taken
        issue(32'h800, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 3'b101, 32'h8, 32'h8000_0000, 32'd1);
        chk("bge_upd_taken", bus.upd_taken, 32'd0);
        chk("bge_redirect", bus.redirect, 32'd0);
        step();

        // funct3 010 never taken
        issue(32'h900, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 3'b010, 32'h8, 32'd3, 32'd3);
        chk("f3_010_taken", bus.upd_taken, 32'd0);
        chk("f3_010_redirect", bus.redirect, 32'd0);
        step();

        // Non-control instruction carrying pred_taken=1
        issue(32'hA00, 1'b1, 32'hA40, 1'b0, 1'b0, 1'b0, 3'b000, 32'h40, 32'd0, 32'd0);
        chk("nonctl_upd_valid", bus.upd_valid, 32'd0);
        chk("nonctl_prev", bus.upd_prev_taken, 32'd0);
        chk("nonctl_redirect", bus.redirect, 32'd0);
        step();

        // JAL with wrapping target
        issue(32'hFFFF_FFF0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h20, 32'd0, 32'd0);
        chk("jal_wrap_redirect", bus.redirect, 32'd1);
        chk("jal_wrap_pc", bus.redirect_pc, 32'h10);
        step();

        // Stall holds IF/ID one cycle and bubbles ID/EX
        drive_if(1'b1, 32'h700, 1'b1, 32'h708);
        step();
        drive_if(1'b0, 32'd0, 1'b0, 32'd0);
        drive_id(1'b0, 1'b1, 1'b0, 3'd0, 32'h8);
        bus.stall = 1'b1;
        step();
        bus.stall = 1'b0;
        #1;
        chk("stall_bubble", bus.upd_valid, 32'd0);
        step();
        drive_id(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
        #1;
        chk("stall_jal_valid", bus.upd_valid, 32'd1);
        chk("stall_jal_target", bus.upd_target, 32'h708);
        chk("stall_jal_redirect", bus.redirect, 32'd0);
        chk("stall_jal_link", bus.ex_link, 32'h704);
        step();

        // Back-to-back branches with stall raised during the mispredict
        drive_if(1'b1, 32'h600, 1'b0, 32'h0);
        step();
        drive_if(1'b1, 32'h604, 1'b0, 32'h0);
        drive_id(1'b1, 1'b0, 1'b0, 3'b000, 32'h10);
        step();
        drive_if(1'b1, 32'h608, 1'b0, 32'h0);
        bus.ex_rs1 = 32'd7;
        bus.ex_rs2 = 32'd7;
        bus.stall  = 1'b1;
        #1;
        chk("b2b_redirect", bus.redirect, 32'd1);
        chk("b2b_redirect_pc", bus.redirect_pc, 32'h610);
        step();
        bus.stall = 1'b0;
        drive_if(1'b0, 32'd0, 1'b0, 32'd0);
        #1;
        chk("b2b_ex_squashed", bus.upd_valid, 32'd0);
        chk("b2b_no_redirect", bus.redirect, 32'd0);
        step();
        chk("b2b_ifid_squashed", bus.upd_valid, 32'd0);
        drive_id(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
        step();

        // Reset mid-flight with a predicted-taken branch in IF/ID
        drive_if(1'b1, 32'hB00, 1'b1, 32'hC00);
        step();
        drive_if(1'b1, 32'hB04, 1'b1, 32'hC00);
        drive_id(1'b1, 1'b0, 1'b0, 3'b000, 32'h100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive_if(1'b0, 32'd0, 1'b0, 32'd0);
        bus.ex_rs1 = 32'd0;
        bus.ex_rs2 = 32'd1;
        #1;
        chk("midrst_upd_valid", bus.upd_valid, 32'd0);
        chk("midrst_redirect", bus.redirect, 32'd0);
        chk("midrst_perf_br", bus.perf_branch_cnt, 32'd0);
        chk("midrst_perf_mp", bus.perf_mispred_cnt, 32'd0);
        step();
        chk("midrst_upd_valid2", bus.upd_valid, 32'd0);
        drive_id(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- EX-stage branch resolution and predictor-update source for the 5-stage RISC-V core; the write side of the IF-stage branch target buffer.
- Carries IF prediction metadata (pred taken, pred target) through IF/ID and ID/EX registers, then resolves conditional branches, JAL and JALR in EX.
- Emits the BTB update bundle and a pipeline redirect (correct next PC plus squash of younger stages) on a misprediction.

Parameters:
- XLEN, 32, datapath and PC width.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous reset, active-high
- if_valid  in  1  IF holds a real instruction
- if_pc  in  XLEN  PC of the IF instruction
- if_pred_taken  in  1  BTB prediction taken for if_pc
- if_pred_target  in  XLEN  BTB predicted target; don't-care when if_pred_taken=0
- stall  in  1  hazard unit: hold IF/ID, insert bubble into ID/EX
- id_is_branch  in  1  ID decoder: conditional branch
- id_is_jal  in  1  ID decoder: JAL
- id_is_jalr  in  1  ID decoder: JALR
- id_funct3  in  3  ID branch condition code
- id_imm  in  XLEN  ID sign-extended immediate
- ex_rs1  in  XLEN  forwarded rs1 value for the EX instruction
- ex_rs2  in  XLEN  forwarded rs2 value for the EX instruction
- upd_valid  out  1  BTB update strobe (EX holds a control-transfer instruction)
- upd_pc  out  XLEN  PC of the resolved instruction
- upd_taken  out  1  actual direction
- upd_prev_taken  out  1  direction that was predicted
- upd_target  out  XLEN  actual taken target
- redirect  out  1  misprediction: fetch from redirect_pc, squash younger stages
- redirect_pc  out  XLEN  correct next PC
- ex_link  out  XLEN  EX PC+4, the rd write value for JAL and JALR
- perf_branch_cnt  out  32  resolved control-transfer count (optional feature)
- perf_mispred_cnt  out  32  misprediction count (optional feature)

Behaviour:
- Reset: rst sampled on the clk edge. Clears IF/ID and ID/EX valid bits and all metadata to 0.
- Outputs after reset: upd_valid=0, redirect=0, redirect_pc=0, ex_link=4, perf counters=0.
- IF/ID register: captures if_valid, if_pc, if_pred_taken and if_pred_target each cycle. It holds when stall=1. Its valid bit clears if redirect=1, and redirect wins over stall.
- ID/EX register: captures IF/ID contents plus the ID decode inputs. It loads a bubble (valid=0) when stall=1 or redirect=1.
- Latency: an instruction reaches EX 2 cycles after IF when there is no stall. All EX outputs are combinational from the ID/EX register and ex_rs1/ex_rs2, so resolution is visible in the same cycle.
- Branch condition by funct3:
  - 000 BEQ; 001 BNE.
  - 100 BLT and 101 BGE, signed compare.
  - 110 BLTU and 111 BGEU, unsigned compare.
  - 010 and 011 resolve as not taken.
- JAL and JALR are always taken.
- Target arithmetic, modulo 2^32 (wrap):
  - branch and JAL: pc+imm.
  - JALR: (rs1+imm) with bit 0 cleared.
- upd_valid = ex_valid & (is_branch | is_jal | is_jalr). Asserted for exactly one cycle per resolved instruction.
- upd_target: computed target, valid even when not taken.
- When upd_valid=0: upd_taken=0 and upd_prev_taken=0.
- mispredict = upd_valid & ((taken != pred_taken) | (taken & pred_taken & target != pred_target)).
- redirect = mispredict. redirect_pc = target if taken, else pc+4.
- A non-control instruction, or a bubble, never redirects, even if it carries pred_taken=1.
- Simultaneous stall and redirect: both pipeline registers squash; stall is ignored that cycle.
- Back-to-back branches: the second branch is squashed by the first branch's redirect and never raises upd_valid.
- Reset asserted mid-flight: in-flight predictions are discarded with no update strobe.

Optional Feature:
- Macro BRU_PERF_CNT_EN.
- Defined:
  - perf_branch_cnt increments on every upd_valid cycle.
  - perf_mispred_cnt increments on every redirect cycle.
  - Both wrap at 2^32 and both clear on rst.
- Undefined: both ports are tied to 0 and no counter flops are instantiated.

Test Plan:
- Correctly predicted taken: BEQ at 0x100, imm=0x20, rs1=rs2=5, pred_taken=1, pred_target=0x120 -> upd_valid=1, upd_taken=1, upd_target=0x120, redirect=0.
- Direction mispredict: BLT at 0x200, rs1=0xFFFFFFFF, rs2=1, pred_taken=0 -> taken (signed), redirect=1, redirect_pc=0x200+imm; the next cycle's EX valid=0.
- Wrong target: JALR at 0x300, rs1=0x1003, imm=0, pred_target=0x2000 -> redirect=1, redirect_pc=0x1002, ex_link=0x304.
- Predicted taken but not taken: BGEU at 0x400, rs1=1, rs2=2, pred_taken=1 -> upd_taken=0, upd_prev_taken=1, redirect_pc=0x404.
- Stall with simultaneous redirect: stall=1 in the mispredict cycle -> IF/ID and ID/EX both invalid next cycle, and no second upd_valid.
- Counters and reset: 3 branches with 1 mispredict, then rst mid-flight -> with BRU_PERF_CNT_EN, counts go 3/1, then 0/0 with upd_valid=0 after reset. Without the macro, counts stay 0.
